// File: rtl/adc_capture_trigger.sv
// ADC capture front end: registers raw samples, decimates them, detects the trigger
// and drives the write side of the pre-trigger FIFO until the post-trigger count is met.
module adc_capture_trigger #(
  parameter int ADC_WIDTH   = 10,
  parameter int DECIM_WIDTH = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic [ADC_WIDTH-1:0]   adc_data,
  input  logic                   arm,
  input  logic [1:0]             trig_mode,
  input  logic [ADC_WIDTH-1:0]   trig_level,
  input  logic                   ext_trigger,
  input  logic [DECIM_WIDTH-1:0] decimate,
  input  logic [CNT_WIDTH-1:0]   post_samples,
  input  logic                   fifo_full,
  output logic [ADC_WIDTH-1:0]   wr_data,
  output logic                   wr_ce,
  output logic                   wr_trigger,
  output logic                   armed,
  output logic                   capturing,
  output logic                   capture_done,
  output logic                   overflow
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [ADC_WIDTH-1:0]   adc_q;
  logic [ADC_WIDTH-1:0]   prev;
  logic                   prev_valid;
  logic [DECIM_WIDTH-1:0] dcnt;
  logic [CNT_WIDTH-1:0]   pcnt;
  logic [CNT_WIDTH-1:0]   pcnt_nxt;
  logic [CNT_WIDTH-1:0]   pcnt_inc;
  logic [CNT_WIDTH-1:0]   post_eff;
  logic                   tick;
  logic                   trig_hit;
  logic                   wr_en;
  logic                   trig_en;
  logic                   ovf_set;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    tick     = (dcnt == '0);
    post_eff = (post_samples == '0) ? CNT_WIDTH'(1) : post_samples;
    pcnt_inc = sat_inc(pcnt);

    // Mode 3 fires on the first tick after arm, which is exactly when prev is not yet valid.
    case (trig_mode)
      2'd0:    trig_hit = prev_valid && (prev < trig_level) && (adc_q >= trig_level);
      2'd1:    trig_hit = prev_valid && (prev > trig_level) && (adc_q <= trig_level);
      2'd2:    trig_hit = ext_trigger;
      default: trig_hit = !prev_valid;
    endcase

    state_nxt = state;
    pcnt_nxt  = pcnt;
    wr_en     = 1'b0;
    trig_en   = 1'b0;
    ovf_set   = 1'b0;

    if (arm) begin
      state_nxt = S_ARMED;
      pcnt_nxt  = '0;
    end else if (tick) begin
      case (state)
        S_ARMED: begin
          if (!fifo_full) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              trig_en   = 1'b1;
              pcnt_nxt  = CNT_WIDTH'(1);
              state_nxt = (post_eff <= CNT_WIDTH'(1)) ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (fifo_full) begin
            ovf_set   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            wr_en    = 1'b1;
            pcnt_nxt = pcnt_inc;
            if (pcnt_inc >= post_eff) state_nxt = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output register stage
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      dcnt         <= '0;
      prev_valid   <= 1'b0;
      pcnt         <= '0;
      wr_data      <= '0;
      wr_ce        <= 1'b0;
      wr_trigger   <= 1'b0;
      armed        <= 1'b0;
      capturing    <= 1'b0;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;

      if (arm || dcnt >= decimate) dcnt <= '0;
      else                         dcnt <= dcnt + DECIM_WIDTH'(1);

      if (arm)       prev_valid <= 1'b0;
      else if (tick) prev_valid <= 1'b1;

      wr_ce      <= wr_en;
      wr_trigger <= trig_en;
      if (wr_en) wr_data <= adc_q;

      armed        <= (state_nxt == S_ARMED);
      capturing    <= (state_nxt == S_CAPTURE);
      capture_done <= (state_nxt == S_DONE);

      if (arm)          overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  // Sample register stage
  always_ff @(posedge wr_clk) begin
    adc_q <= adc_data;
    if (tick && !arm) prev <= adc_q;
  end

endmodule
